// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared definitions for the AXI-lite memory responder.
// Holds the response codes and the FSM state encodings. The bus and the
// testbench import these so that everyone agrees on the same values.
package axi_lite_mem_slave_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOTA,
    W_GOTD,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI-lite channel bundle between a requester (master) and axi_lite_mem_slave (slave).
// Ports: the AW, W, B, AR and R channels. Signal names follow the s0_axi_* names
// used on the original flat port list. The clock and reset are not part of the bundle.
interface axi_lite_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr;
  logic                    s0_axi_awvalid;
  logic                    s0_axi_awready;
  logic [DATA_WIDTH-1:0]   s0_axi_wdata;
  logic [DATA_WIDTH/8:0]   s0_axi_wstrb;
  logic                    s0_axi_wvalid;
  logic                    s0_axi_wready;
  logic [RESP_WIDTH-1:0]   s0_axi_bresp;
  logic                    s0_axi_bvalid;
  logic                    s0_axi_bready;
  logic [ADDR_WIDTH-1:0]   s0_axi_araddr;
  logic                    s0_axi_arvalid;
  logic                    s0_axi_arready;
  logic [DATA_WIDTH-1:0]   s0_axi_rdata;
  logic [RESP_WIDTH-1:0]   s0_axi_rresp;
  logic                    s0_axi_rvalid;
  logic                    s0_axi_rready;

  modport master (
    output s0_axi_awaddr, s0_axi_awvalid, s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid,
           s0_axi_bready, s0_axi_araddr, s0_axi_arvalid, s0_axi_rready,
    input  s0_axi_awready, s0_axi_wready, s0_axi_bresp, s0_axi_bvalid,
           s0_axi_arready, s0_axi_rdata, s0_axi_rresp, s0_axi_rvalid
  );

  modport slave (
    input  s0_axi_awaddr, s0_axi_awvalid, s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid,
           s0_axi_bready, s0_axi_araddr, s0_axi_arvalid, s0_axi_rready,
    output s0_axi_awready, s0_axi_wready, s0_axi_bresp, s0_axi_bvalid,
           s0_axi_arready, s0_axi_rdata, s0_axi_rresp, s0_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_mem_array.sv
// Word storage for axi_lite_mem_slave.
// Ports: clk/rst_n (async active-low, clears all words); byte-enabled write port
// (wr_en, wr_idx, wr_data, wr_strb); registered read port (rd_en, rd_idx, rd_hit,
// rd_data). A read with rd_hit low returns zero. A read and a write to the same word
// on one edge return the old contents.
module axi_lite_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_WIDTH-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [IDX_WIDTH-1:0]    rd_idx,
  input  logic                    rd_hit,
  output logic [DATA_WIDTH-1:0]   rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= rd_hit ? mem[rd_idx] : '0;
  end
endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-lite memory responder holding DEPTH words of DATA_WIDTH bits.
// Ports: s0_axi_aclk (rising-edge clock), s0_axi_aresetn (async active-low reset),
// axi (slave side of the AW/W/B/AR/R channel bundle).
// Independent write and read FSMs. Out-of-range word indices answer SLVERR,
// leave storage untouched and read back as zero.
module axi_lite_mem_slave
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned DEPTH      = 16
) (
  input logic                 s0_axi_aclk,
  input logic                 s0_axi_aresetn,
  axi_lite_mem_slave_if.slave axi
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a[ADDR_WIDTH-1:2]) < DEPTH;
  endfunction

  // Readies stay low while in reset and become active from the first edge after release.
  logic ready_en;
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) ready_en <= 1'b0;
    else ready_en <= 1'b1;
  end

  // ---------------- write channel ----------------
  wstate_t                 wstate, wnext;
  logic                    awready, wready, bvalid, aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0]   awaddr_q, wr_addr;
  logic [DATA_WIDTH-1:0]   wdata_q, wr_data;
  logic [STRB_WIDTH-1:0]   wstrb_q, wr_strb;
  logic [RESP_WIDTH-1:0]   bresp_q;

  assign aw_hs = axi.s0_axi_awvalid & awready;
  assign w_hs  = axi.s0_axi_wvalid & wready;

  always_comb begin
    wnext   = wstate;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        awready = ready_en;
        wready  = ready_en;
        if (aw_hs && w_hs) wnext = W_RESP;
        else if (aw_hs)    wnext = W_GOTA;
        else if (w_hs)     wnext = W_GOTD;
      end
      W_GOTA: begin
        wready = 1'b1;
        if (w_hs) wnext = W_RESP;
      end
      W_GOTD: begin
        awready = 1'b1;
        if (aw_hs) wnext = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (axi.s0_axi_bready) wnext = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

  // The committing edge takes whichever half arrived earlier from its holding
  // register and the other half straight from the bus.
  assign commit  = (wstate != W_RESP) && (wnext == W_RESP);
  assign wr_addr = (wstate == W_GOTA) ? awaddr_q : axi.s0_axi_awaddr;
  assign wr_data = (wstate == W_GOTD) ? wdata_q : axi.s0_axi_wdata;
  assign wr_strb = (wstate == W_GOTD) ? wstrb_q : axi.s0_axi_wstrb[STRB_WIDTH-1:0];

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wstate   <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
    end else begin
      wstate <= wnext;
      if (aw_hs) awaddr_q <= axi.s0_axi_awaddr;
      if (w_hs) begin
        wdata_q <= axi.s0_axi_wdata;
        wstrb_q <= axi.s0_axi_wstrb[STRB_WIDTH-1:0];
      end
      if (commit) bresp_q <= in_range(wr_addr) ? OKAY : SLVERR;
    end
  end

  // ---------------- read channel ----------------
  rstate_t               rstate, rnext;
  logic                  arready, rvalid, ar_hs;
  logic [RESP_WIDTH-1:0] rresp_q;
  logic [DATA_WIDTH-1:0] rdata;

  assign ar_hs = axi.s0_axi_arvalid & arready;

  always_comb begin
    rnext   = rstate;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (rstate)
      R_IDLE: begin
        arready = ready_en;
        if (ar_hs) rnext = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (axi.s0_axi_rready) rnext = R_IDLE;
      end
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rstate  <= R_IDLE;
      rresp_q <= '0;
    end else begin
      rstate <= rnext;
      if (ar_hs) rresp_q <= in_range(axi.s0_axi_araddr) ? OKAY : SLVERR;
    end
  end

  axi_lite_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clk     (s0_axi_aclk),
    .rst_n   (s0_axi_aresetn),
    .wr_en   (commit && in_range(wr_addr)),
    .wr_idx  (wr_addr[IDX_WIDTH+1:2]),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (ar_hs),
    .rd_idx  (axi.s0_axi_araddr[IDX_WIDTH+1:2]),
    .rd_hit  (in_range(axi.s0_axi_araddr)),
    .rd_data (rdata)
  );

  assign axi.s0_axi_awready = awready;
  assign axi.s0_axi_wready  = wready;
  assign axi.s0_axi_bvalid  = bvalid;
  assign axi.s0_axi_bresp   = bresp_q;
  assign axi.s0_axi_arready = arready;
  assign axi.s0_axi_rvalid  = rvalid;
  assign axi.s0_axi_rresp   = rresp_q;
  assign axi.s0_axi_rdata   = rdata;

  // Byte offset bits and the top strobe bit carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0], axi.s0_axi_araddr[1:0], axi.s0_axi_wstrb[STRB_WIDTH]};
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
module tb_axi_lite_mem_slave;
  import axi_lite_mem_slave_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned RW    = 3;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus ();

  axi_lite_mem_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW),
    .DEPTH      (DEPTH)
  ) dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .axi            (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference memory: plain array of words, updated by byte lanes.
  logic [DW-1:0] model [DEPTH];

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (int'(a) / 4) < DEPTH;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    return addr_ok(a) ? model[int'(a) / 4] : '0;
  endfunction

  function automatic logic [RW-1:0] exp_resp(input logic [AW-1:0] a);
    return addr_ok(a) ? RW'(RESP_OKAY) : RW'(RESP_SLVERR);
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8:0] s);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < DW / 8; b++) if (s[b]) mask = mask | (DW'(32'hFF) << (8 * b));
    if (addr_ok(a)) model[int'(a) / 4] = (model[int'(a) / 4] & ~mask) | (d & mask);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Drives AW and W with independent start delays, then waits for the response.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8:0] s,
                           input int unsigned aw_dly, input int unsigned w_dly,
                           output logic [RW-1:0] resp, output int unsigned lat, output bit to);
    bit aw_done, w_done, aw_fire, w_fire;
    int unsigned cyc;
    aw_done = 0; w_done = 0; cyc = 0; to = 0; lat = 0; resp = '0;
    bus.s0_axi_awaddr = a;
    bus.s0_axi_wdata  = d;
    bus.s0_axi_wstrb  = s;
    while (!(aw_done && w_done) && cyc < 60) begin
      if (!aw_done && cyc >= aw_dly) bus.s0_axi_awvalid = 1'b1;
      if (!w_done && cyc >= w_dly) bus.s0_axi_wvalid = 1'b1;
      @(negedge clk);
      aw_fire = bus.s0_axi_awvalid && bus.s0_axi_awready;
      w_fire  = bus.s0_axi_wvalid && bus.s0_axi_wready;
      @(posedge clk); #1;
      if (aw_fire) begin aw_done = 1; bus.s0_axi_awvalid = 1'b0; end
      if (w_fire) begin w_done = 1; bus.s0_axi_wvalid = 1'b0; end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      to = 1;
      bus.s0_axi_awvalid = 1'b0;
      bus.s0_axi_wvalid  = 1'b0;
      return;
    end
    while (!bus.s0_axi_bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!bus.s0_axi_bvalid) begin to = 1; return; end
    resp = bus.s0_axi_bresp;
    if (bus.s0_axi_bready) begin @(posedge clk); #1; end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [RW-1:0] resp,
                          output int unsigned lat, output bit to);
    bit fired;
    int unsigned cyc;
    fired = 0; cyc = 0; to = 0; lat = 0; d = '0; resp = '0;
    bus.s0_axi_araddr  = a;
    bus.s0_axi_arvalid = 1'b1;
    while (!fired && cyc < 60) begin
      @(negedge clk);
      fired = bus.s0_axi_arready;
      @(posedge clk); #1;
      cyc++;
    end
    bus.s0_axi_arvalid = 1'b0;
    if (!fired) begin to = 1; return; end
    while (!bus.s0_axi_rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!bus.s0_axi_rvalid) begin to = 1; return; end
    d = bus.s0_axi_rdata;
    resp = bus.s0_axi_rresp;
    if (bus.s0_axi_rready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 000", {bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready});
    end
    n_checks++;
    if ({bus.s0_axi_bvalid, bus.s0_axi_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b want 00", {bus.s0_axi_bvalid, bus.s0_axi_rvalid});
    end
    n_checks++;
    if (bus.s0_axi_rdata !== '0 || bus.s0_axi_rresp !== '0 || bus.s0_axi_bresp !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata %h rresp %0d bresp %0d want 0", bus.s0_axi_rdata, bus.s0_axi_rresp, bus.s0_axi_bresp);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.s0_axi_awready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: awready %b want 0", bus.s0_axi_awready);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_release: got %b want 111", {bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready});
    end
  endtask

  task automatic test_basic();
    logic [RW-1:0] resp; logic [DW-1:0] d; int unsigned lat; bit to;
    axi_write(8'h00, 32'd56, 5'h0F, 0, 0, resp, lat, to);
    model_write(8'h00, 32'd56, 5'h0F);
    n_checks++;
    if (to || lat != 0 || resp !== 3'd0) begin
      n_fail++; $display("FAIL basic_write: to %0d lat %0d bresp %0d want to 0 lat 0 bresp 0", to, lat, resp);
    end
    axi_read(8'h00, d, resp, lat, to);
    n_checks++;
    if (to || lat != 0 || d !== 32'd56 || resp !== 3'd0) begin
      n_fail++; $display("FAIL basic_read: to %0d lat %0d rdata %0d rresp %0d want 0 0 56 0", to, lat, d, resp);
    end
  endtask

  task automatic test_strobe();
    logic [RW-1:0] resp; logic [DW-1:0] d; int unsigned lat; bit to;
    axi_write(8'h08, 32'hAABBCCDD, 5'h0F, 0, 0, resp, lat, to);
    model_write(8'h08, 32'hAABBCCDD, 5'h0F);
    axi_write(8'h08, 32'h00000011, 5'h01, 0, 0, resp, lat, to);
    model_write(8'h08, 32'h00000011, 5'h01);
    axi_read(8'h08, d, resp, lat, to);
    n_checks++;
    if (to || d !== 32'hAABBCC11 || resp !== 3'd0) begin
      n_fail++; $display("FAIL strobe_merge: to %0d rdata %h want aabbcc11", to, d);
    end
  endtask

  task automatic test_split_order();
    logic [RW-1:0] resp; logic [DW-1:0] d; int unsigned lat; bit to;
    // W first, AW three idle cycles later
    axi_write(8'h14, 32'h12345678, 5'h0F, 4, 0, resp, lat, to);
    model_write(8'h14, 32'h12345678, 5'h0F);
    n_checks++;
    if (to || lat != 0 || resp !== 3'd0 || bus.s0_axi_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL w_before_aw: to %0d lat %0d bresp %0d bvalid_after %b want 0 0 0 0", to, lat, resp, bus.s0_axi_bvalid);
    end
    axi_read(8'h14, d, resp, lat, to);
    n_checks++;
    if (to || d !== 32'h12345678) begin
      n_fail++; $display("FAIL w_before_aw_data: rdata %h want 12345678", d);
    end
    // AW first, W three idle cycles later
    axi_write(8'h18, 32'hCAFEF00D, 5'h0F, 0, 4, resp, lat, to);
    model_write(8'h18, 32'hCAFEF00D, 5'h0F);
    n_checks++;
    if (to || lat != 0 || resp !== 3'd0 || bus.s0_axi_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL aw_before_w: to %0d lat %0d bresp %0d bvalid_after %b want 0 0 0 0", to, lat, resp, bus.s0_axi_bvalid);
    end
    axi_read(8'h18, d, resp, lat, to);
    n_checks++;
    if (to || d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL aw_before_w_data: rdata %h want cafef00d", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [RW-1:0] resp; logic [DW-1:0] d; int unsigned lat; bit to;
    axi_write(8'h80, 32'hDEADBEEF, 5'h0F, 0, 0, resp, lat, to);
    n_checks++;
    if (to || resp !== 3'd2) begin
      n_fail++; $display("FAIL oor_write: to %0d bresp %0d want 2", to, resp);
    end
    axi_read(8'h80, d, resp, lat, to);
    n_checks++;
    if (to || resp !== 3'd2 || d !== '0) begin
      n_fail++; $display("FAIL oor_read: to %0d rdata %h rresp %0d want 0 2", to, d, resp);
    end
    axi_read(8'h00, d, resp, lat, to);
    n_checks++;
    if (to || d !== exp_rdata(8'h00)) begin
      n_fail++; $display("FAIL oor_no_alias: rdata %h want %h", d, exp_rdata(8'h00));
    end
    // Last in-range word and first word past the end
    axi_write(8'h3F, 32'h0BADC0DE, 5'h0F, 0, 0, resp, lat, to);
    model_write(8'h3F, 32'h0BADC0DE, 5'h0F);
    axi_read(8'h3C, d, resp, lat, to);
    n_checks++;
    if (to || resp !== 3'd0 || d !== 32'h0BADC0DE) begin
      n_fail++; $display("FAIL last_word: rdata %h rresp %0d want 0badc0de 0", d, resp);
    end
    axi_read(8'h40, d, resp, lat, to);
    n_checks++;
    if (to || resp !== 3'd2 || d !== '0) begin
      n_fail++; $display("FAIL first_oor: rdata %h rresp %0d want 0 2", d, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] resp; logic [DW-1:0] d, held; int unsigned lat; bit to;
    bus.s0_axi_bready = 1'b0;
    axi_write(8'h0C, 32'h5A5AA5A5, 5'h0F, 0, 0, resp, lat, to);
    model_write(8'h0C, 32'h5A5AA5A5, 5'h0F);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (to || bus.s0_axi_bvalid !== 1'b1 || bus.s0_axi_bresp !== 3'd0 ||
          bus.s0_axi_awready !== 1'b0 || bus.s0_axi_wready !== 1'b0) begin
        n_fail++; $display("FAIL b_hold: cycle %0d bvalid %b bresp %0d awready %b wready %b want 1 0 0 0",
                           i, bus.s0_axi_bvalid, bus.s0_axi_bresp, bus.s0_axi_awready, bus.s0_axi_wready);
      end
    end
    bus.s0_axi_bready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.s0_axi_bvalid !== 1'b0) begin
      n_fail++; $display("FAIL b_release: bvalid %b want 0", bus.s0_axi_bvalid);
    end
    bus.s0_axi_rready = 1'b0;
    axi_read(8'h0C, held, resp, lat, to);
    // A competing request must wait until the current beat is taken.
    bus.s0_axi_araddr  = 8'h00;
    bus.s0_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (to || bus.s0_axi_rvalid !== 1'b1 || bus.s0_axi_rdata !== 32'h5A5AA5A5 ||
          bus.s0_axi_rresp !== 3'd0 || bus.s0_axi_arready !== 1'b0) begin
        n_fail++; $display("FAIL r_hold: cycle %0d rvalid %b rdata %h arready %b want 1 5a5aa5a5 0",
                           i, bus.s0_axi_rvalid, bus.s0_axi_rdata, bus.s0_axi_arready);
      end
    end
    bus.s0_axi_rready  = 1'b1;
    bus.s0_axi_arvalid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.s0_axi_rvalid !== 1'b0 || held !== 32'h5A5AA5A5) begin
      n_fail++; $display("FAIL r_release: rvalid %b first %h want 0 5a5aa5a5", bus.s0_axi_rvalid, held);
    end
    axi_read(8'h00, d, resp, lat, to);
    n_checks++;
    if (to || d !== exp_rdata(8'h00)) begin
      n_fail++; $display("FAIL after_hold_read: rdata %h want %h", d, exp_rdata(8'h00));
    end
  endtask

  task automatic test_same_edge();
    logic [DW-1:0] old_w, new_w, d; logic [RW-1:0] resp; int unsigned lat; bit to;
    old_w = exp_rdata(8'h08);
    new_w = $urandom;
    bus.s0_axi_awaddr = 8'h08; bus.s0_axi_wdata = new_w; bus.s0_axi_wstrb = 5'h0F;
    bus.s0_axi_araddr = 8'h08;
    bus.s0_axi_awvalid = 1'b1; bus.s0_axi_wvalid = 1'b1; bus.s0_axi_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready} !== 3'b111) begin
      n_fail++; $display("FAIL same_edge_ready: got %b want 111", {bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready});
    end
    @(posedge clk); #1;
    bus.s0_axi_awvalid = 1'b0; bus.s0_axi_wvalid = 1'b0; bus.s0_axi_arvalid = 1'b0;
    n_checks++;
    if (bus.s0_axi_rvalid !== 1'b1 || bus.s0_axi_rdata !== old_w || bus.s0_axi_bvalid !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_old: rvalid %b rdata %h bvalid %b want 1 %h 1",
                         bus.s0_axi_rvalid, bus.s0_axi_rdata, bus.s0_axi_bvalid, old_w);
    end
    model_write(8'h08, new_w, 5'h0F);
    @(posedge clk); #1;
    axi_read(8'h08, d, resp, lat, to);
    n_checks++;
    if (to || d !== new_w) begin
      n_fail++; $display("FAIL same_edge_new: rdata %h want %h", d, new_w);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [DW-1:0] d, wd; logic [DW/8:0] s; logic [RW-1:0] resp;
    int unsigned lat; bit to;
    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 1) == 0) begin
        wd = $urandom;
        s  = (DW/8+1)'($urandom);
        axi_write(a, wd, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat, to);
        n_checks++;
        if (to || resp !== exp_resp(a)) begin
          n_fail++; $display("FAIL rand_write: addr %h to %0d bresp %0d want %0d", a, to, resp, exp_resp(a));
        end
        model_write(a, wd, s);
      end else begin
        axi_read(a, d, resp, lat, to);
        n_checks++;
        if (to || lat != 0 || d !== exp_rdata(a) || resp !== exp_resp(a)) begin
          n_fail++; $display("FAIL rand_read: addr %h to %0d lat %0d rdata %h rresp %0d want %h %0d",
                             a, to, lat, d, resp, exp_rdata(a), exp_resp(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] resp; logic [DW-1:0] d; int unsigned lat; bit to;
    bit saw_b;
    saw_b = 0;
    // Address phase only, leaving the write half done.
    bus.s0_axi_awaddr = 8'h10; bus.s0_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    bus.s0_axi_awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready, bus.s0_axi_bvalid} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b want 0000",
                         {bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready, bus.s0_axi_bvalid});
    end
    // Data offered during reset must be ignored.
    bus.s0_axi_wdata = 32'hFFFFFFFF; bus.s0_axi_wstrb = 5'h0F; bus.s0_axi_wvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.s0_axi_wvalid = 1'b0;
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.s0_axi_bvalid) saw_b = 1;
    end
    n_checks++;
    if (saw_b) begin
      n_fail++; $display("FAIL mid_reset_no_b: bvalid seen 1 want 0");
    end
    axi_read(8'h10, d, resp, lat, to);
    n_checks++;
    if (to || d !== '0) begin
      n_fail++; $display("FAIL mid_reset_word: rdata %h want 0", d);
    end
    axi_read(8'h08, d, resp, lat, to);
    n_checks++;
    if (to || d !== '0) begin
      n_fail++; $display("FAIL mid_reset_cleared: rdata %h want 0", d);
    end
    axi_write(8'h10, 32'h600DCAFE, 5'h0F, 0, 0, resp, lat, to);
    model_write(8'h10, 32'h600DCAFE, 5'h0F);
    n_checks++;
    if (to || resp !== 3'd0) begin
      n_fail++; $display("FAIL post_reset_write: to %0d bresp %0d want 0", to, resp);
    end
    axi_read(8'h10, d, resp, lat, to);
    n_checks++;
    if (to || d !== 32'h600DCAFE || resp !== 3'd0) begin
      n_fail++; $display("FAIL post_reset_read: rdata %h rresp %0d want 600dcafe 0", d, resp);
    end
  endtask

  initial begin
    bus.s0_axi_awaddr = '0; bus.s0_axi_awvalid = 1'b0;
    bus.s0_axi_wdata = '0; bus.s0_axi_wstrb = '0; bus.s0_axi_wvalid = 1'b0;
    bus.s0_axi_bready = 1'b1;
    bus.s0_axi_araddr = '0; bus.s0_axi_arvalid = 1'b0;
    bus.s0_axi_rready = 1'b1;
    model_clear();
    test_reset();
    test_basic();
    test_strobe();
    test_split_order();
    test_out_of_range();
    test_backpressure();
    test_same_edge();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_lite_mem_slave.md
AXI_LITE_MEM_SLAVE -- requirements
Module: axi_lite_mem_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, response field width.
REQ-004 SHALL have parameter DEPTH, default 16, number of DATA_WIDTH words stored.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports, clock and reset first:
 s0_axi_aclk  in  1  clock; all logic on rising edge
 s0_axi_aresetn  in  1  asynchronous active-low reset
 s0_axi_awaddr  in  ADDR_WIDTH  write byte address
 s0_axi_awvalid  in  1 / s0_axi_awready  out  1  write address handshake
 s0_axi_wdata  in  DATA_WIDTH  write data
 s0_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; MSB ignored
 s0_axi_wvalid  in  1 / s0_axi_wready  out  1  write data handshake
 s0_axi_bresp  out  RESP_WIDTH  write response
 s0_axi_bvalid  out  1 / s0_axi_bready  in  1  write response handshake
 s0_axi_araddr  in  ADDR_WIDTH  read byte address
 s0_axi_arvalid  in  1 / s0_axi_arready  out  1  read address handshake
 s0_axi_rdata  out  DATA_WIDTH  read data
 s0_axi_rresp  out  RESP_WIDTH  read response
 s0_axi_rvalid  out  1 / s0_axi_rready  in  1  read data handshake

Function
REQ-006 SHALL act as an AXI-lite responder downstream of the bus m1/m2 ports; handshake completes on a rising edge with valid and ready both high.
REQ-007 SHALL decode word index = addr[ADDR_WIDTH-1:2]; index < DEPTH is in range, else out of range; addr[1:0] ignored.
REQ-008 SHALL encode responses as OKAY = 0, SLVERR = 2, zero-extended to RESP_WIDTH.
REQ-009 Write FSM SHALL have states W_IDLE, W_GOTA, W_GOTD, W_RESP.
REQ-010 W_IDLE: awready = wready = 1; both handshakes -> W_RESP; AW only -> W_GOTA; W only -> W_GOTD.
REQ-011 W_GOTA: awready = 0, wready = 1; W handshake -> W_RESP. W_GOTD: awready = 1, wready = 0; AW handshake -> W_RESP.
REQ-012 On the edge entering W_RESP, an in-range write SHALL update only strobed bytes; an out-of-range write SHALL change no storage.
REQ-013 W_RESP: bvalid = 1, bresp = OKAY or SLVERR per latched address, awready = wready = 0; bready -> W_IDLE; bvalid and bresp held stable until then.
REQ-014 Read FSM SHALL have states R_IDLE (arready = 1, rvalid = 0) and R_DATA (arready = 0, rvalid = 1).
REQ-015 AR handshake SHALL register rdata and rresp and enter R_DATA; rvalid asserts the next cycle (latency 1).
REQ-016 Out-of-range reads SHALL return rdata = 0, rresp = SLVERR.
REQ-017 R_DATA: rdata and rresp held stable; rready -> R_IDLE; a new AR is not accepted until R_IDLE.
REQ-018 Read and write FSMs SHALL run independently. A read capturing the same word on the edge a write commits SHALL return the pre-write data.

Reset
REQ-019 Asserting s0_axi_aresetn low SHALL immediately force W_IDLE and R_IDLE, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, and awready = wready = arready = 0.
REQ-020 While reset is low, ready outputs SHALL be 0; from the first edge after deassertion they follow REQ-010 and REQ-014.
REQ-021 Reset SHALL clear storage to 0. Reset mid-transaction SHALL drop the transaction with no response and no partial write.

Structure
REQ-022 Response codes and FSM state encodings SHALL live in a shared package for reuse by bus and testbench.
REQ-023 Storage SHALL be one sub-module, axi_lite_mem_array: byte-enabled write port plus registered read port.

Verification
REQ-024 AW+W addr 0x00, data 56, strb 0xF in one cycle, bready = 1 -> bvalid one cycle later, bresp 0; AR 0x00 -> rdata 56, rresp 0, rvalid one cycle after AR.
REQ-025 Write 0xAABBCCDD to 0x08, then 0x00000011 with strb 0x1 -> read 0x08 returns 0xAABBCC11.
REQ-026 W data before AW (3-cycle gap) and AW before W -> both end in a single bvalid with bresp 0 and the correct data stored.
REQ-027 Write and read at 0x80 (DEPTH 16) -> bresp 2, rresp 2, rdata 0; read of 0x00 is unchanged.
REQ-028 bready held 0 for 5 cycles -> bvalid stays 1, awready = wready = 0; rready 0 -> rvalid and rdata stable.
REQ-029 Reset asserted in W_GOTA -> no bvalid, storage 0; after release the next write and read complete normally.
